// File: rtl/arm_pkg.sv
// Shared EXE command encodings, condition-flag bit positions and the
// exception-banking state type used by the status register unit.
package arm_pkg;

  // CMP issues as EXE_SUB and TST as EXE_AND; only the S bit tells them apart.
  localparam logic [3:0] EXE_MOV = 4'd1;
  localparam logic [3:0] EXE_ADD = 4'd2;
  localparam logic [3:0] EXE_ADC = 4'd3;
  localparam logic [3:0] EXE_SUB = 4'd4;
  localparam logic [3:0] EXE_SBC = 4'd5;
  localparam logic [3:0] EXE_AND = 4'd6;
  localparam logic [3:0] EXE_ORR = 4'd7;
  localparam logic [3:0] EXE_EOR = 4'd8;
  localparam logic [3:0] EXE_MVN = 4'd9;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_NORMAL,
    ST_SAVED
  } exc_state_t;

endpackage

// File: rtl/flag_gen.sv
// Combinational NZCV derivation from the ALU result; flags the command
// does not define are passed through from the current status word.
module flag_gen
  import arm_pkg::*;
(
  input  logic [3:0] alu_cmd,
  input  logic       a_msb,
  input  logic       b_msb,
  input  logic       res_msb,
  input  logic       res_zero,
  input  logic       alu_cout,
  input  logic [3:0] cur_flags,
  output logic [3:0] new_flags
);

  always_comb begin
    new_flags = cur_flags;
    case (alu_cmd)
      EXE_ADD, EXE_ADC: begin
        new_flags[FLAG_N] = res_msb;
        new_flags[FLAG_Z] = res_zero;
        new_flags[FLAG_C] = alu_cout;
        new_flags[FLAG_V] = (a_msb == b_msb) && (res_msb != a_msb);
      end
      // Carry is already NOT-borrow on the ALU side, so it is taken as-is.
      EXE_SUB, EXE_SBC: begin
        new_flags[FLAG_N] = res_msb;
        new_flags[FLAG_Z] = res_zero;
        new_flags[FLAG_C] = alu_cout;
        new_flags[FLAG_V] = (a_msb != b_msb) && (res_msb != a_msb);
      end
      EXE_MOV, EXE_MVN, EXE_AND, EXE_ORR, EXE_EOR: begin
        new_flags[FLAG_N] = res_msb;
        new_flags[FLAG_Z] = res_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/status_register_unit.sv
// Architectural NZCV status register with exception-entry banking.
// Optional macro STATUS_FWD_EN adds a same-cycle bypass on status_fwd.
module status_register_unit
  import arm_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        alu_cmd,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_cout,
  input  logic              upd_valid,
  input  logic              s_bit,
  input  logic              flush,
  input  logic              exc_enter,
  input  logic              exc_return,
  output logic [3:0]        status_reg,
  output logic [3:0]        status_fwd,
  output logic              banked,
  output logic              nest_err
);

  logic [3:0] status_q;
  logic [3:0] shadow_q;
  logic [3:0] new_flags;
  logic [3:0] post_update;
  exc_state_t state_q;
  exc_state_t state_next;
  logic       nest_q;
  logic       we;
  logic       take_return;
  logic       take_enter;
  logic       nest_hit;
  logic       unused_operand_bits;

  // Only the sign bits of the operands matter for overflow detection.
  assign unused_operand_bits = ^{op_a[DATA_W-2:0], op_b[DATA_W-2:0]};

  flag_gen u_flag_gen (
    .alu_cmd   (alu_cmd),
    .a_msb     (op_a[DATA_W-1]),
    .b_msb     (op_b[DATA_W-1]),
    .res_msb   (alu_res[DATA_W-1]),
    .res_zero  (alu_res == '0),
    .alu_cout  (alu_cout),
    .cur_flags (status_q),
    .new_flags (new_flags)
  );

  assign we          = upd_valid & s_bit & ~flush;
  assign post_update = we ? new_flags : status_q;

  // A simultaneous return always wins, so a colliding entry is simply dropped.
  assign take_return = exc_return && (state_q == ST_SAVED);
  assign take_enter  = exc_enter && !exc_return && (state_q == ST_NORMAL);
  assign nest_hit    = exc_enter && !exc_return && (state_q == ST_SAVED);

  always_comb begin
    state_next = state_q;
    if (take_return) begin
      state_next = ST_NORMAL;
    end else if (take_enter) begin
      state_next = ST_SAVED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= RESET_FLAGS;
      shadow_q <= 4'b0000;
      state_q  <= ST_NORMAL;
      nest_q   <= 1'b0;
    end else begin
      if (take_return) begin
        status_q <= shadow_q;
      end else if (we) begin
        status_q <= new_flags;
      end
      if (take_enter) begin
        shadow_q <= post_update;
      end
      if (nest_hit) begin
        nest_q <= 1'b1;
      end
      state_q <= state_next;
    end
  end

  assign status_reg = status_q;
  assign banked     = (state_q == ST_SAVED);
  assign nest_err   = nest_q;

`ifdef STATUS_FWD_EN
  assign status_fwd = take_return ? shadow_q : post_update;
`else
  assign status_fwd = status_q;
`endif

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit: directed scenarios plus a
// randomized run against an arithmetic flag model (honours STATUS_FWD_EN).
module tb_status_register_unit;
  import arm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_cmd;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        alu_cout;
  logic        upd_valid;
  logic        s_bit;
  logic        flush;
  logic        exc_enter;
  logic        exc_return;
  logic [3:0]  status_reg;
  logic [3:0]  status_fwd;
  logic        banked;
  logic        nest_err;

  int n_compared;
  int n_mismatched;

  // Reference model state
  logic [3:0] m_flags;
  logic [3:0] m_shadow;
  logic       m_saved;
  logic       m_nest;

  status_register_unit #(.DATA_W(32), .RESET_FLAGS(4'b0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_cmd    (alu_cmd),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_res    (alu_res),
    .alu_cout   (alu_cout),
    .upd_valid  (upd_valid),
    .s_bit      (s_bit),
    .flush      (flush),
    .exc_enter  (exc_enter),
    .exc_return (exc_return),
    .status_reg (status_reg),
    .status_fwd (status_fwd),
    .banked     (banked),
    .nest_err   (nest_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags from true signed arithmetic on the operands rather than sign-bit rules.
  function automatic logic [3:0] model_flags(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] r,
                                             input logic co);
    logic [3:0] f;
    longint     v;
    f = m_flags;
    if (c inside {EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC, EXE_MOV, EXE_MVN,
                  EXE_AND, EXE_ORR, EXE_EOR}) begin
      f[FLAG_Z] = (r == 32'd0);
      f[FLAG_N] = r[31];
    end
    if (c == EXE_ADD || c == EXE_ADC) begin
      v = longint'($signed(a)) + longint'($signed(b)) + ((c == EXE_ADC && m_flags[FLAG_C]) ? 1 : 0);
      f[FLAG_C] = co;
      f[FLAG_V] = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    end else if (c == EXE_SUB || c == EXE_SBC) begin
      v = longint'($signed(a)) - longint'($signed(b)) - ((c == EXE_SBC && !m_flags[FLAG_C]) ? 1 : 0);
      f[FLAG_C] = co;
      f[FLAG_V] = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    end
    return f;
  endfunction

  function automatic logic [3:0] model_fwd();
    logic       w;
    logic [3:0] nf;
    w  = upd_valid && s_bit && !flush;
    nf = model_flags(alu_cmd, op_a, op_b, alu_res, alu_cout);
`ifdef STATUS_FWD_EN
    if (exc_return && m_saved) return m_shadow;
    return w ? nf : m_flags;
`else
    return m_flags;
`endif
  endfunction

  // Produces an ALU result and carry consistent with the operands.
  task automatic make_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic co);
    logic [32:0] t;
    t  = 33'd0;
    co = 1'($urandom_range(0, 1));
    case (c)
      EXE_ADD: t = {1'b0, a} + {1'b0, b};
      EXE_ADC: t = {1'b0, a} + {1'b0, b} + {32'd0, m_flags[FLAG_C]};
      EXE_SUB: t = {1'b0, a} + {1'b0, ~b} + 33'd1;
      EXE_SBC: t = {1'b0, a} + {1'b0, ~b} + {32'd0, m_flags[FLAG_C]};
      EXE_AND: t = {co, a & b};
      EXE_ORR: t = {co, a | b};
      EXE_EOR: t = {co, a ^ b};
      EXE_MOV: t = {co, b};
      EXE_MVN: t = {co, ~b};
      default: t = {co, $urandom()};
    endcase
    r  = t[31:0];
    co = t[32];
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic uv, input logic sb, input logic fl,
                       input logic en, input logic rt);
    logic [31:0] r;
    logic        co;
    make_op(c, a, b, r, co);
    alu_cmd = c; op_a = a; op_b = b; alu_res = r; alu_cout = co;
    upd_valid = uv; s_bit = sb; flush = fl; exc_enter = en; exc_return = rt;
    #1;
  endtask

  // Advances one clock and moves the model to the post-edge state.
  task automatic tick();
    logic       w;
    logic [3:0] nf;
    logic [3:0] post;
    w    = upd_valid && s_bit && !flush;
    nf   = model_flags(alu_cmd, op_a, op_b, alu_res, alu_cout);
    post = w ? nf : m_flags;
    @(posedge clk);
    #1;
    if (exc_return && m_saved) begin
      m_flags = m_shadow;
      m_saved = 1'b0;
    end else begin
      m_flags = post;
      if (exc_enter && !exc_return) begin
        if (m_saved) m_nest = 1'b1;
        else begin
          m_shadow = post;
          m_saved  = 1'b1;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_flags = 4'b0000; m_shadow = 4'b0000; m_saved = 1'b0; m_nest = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_cmd = 4'd0; op_a = '0; op_b = '0; alu_res = '0; alu_cout = 1'b0;
    upd_valid = 1'b0; s_bit = 1'b0; flush = 1'b0; exc_enter = 1'b0; exc_return = 1'b0;
    model_reset();
    #1;
    n_compared++;
    if (status_reg !== 4'b0000) begin
      n_mismatched++; $display("[TB] FAIL reset_status got %b want %b", status_reg, 4'b0000);
    end
    n_compared++;
    if (banked !== 1'b0 || nest_err !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_bank got banked=%b nest=%b want 0 0", banked, nest_err);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    logic [3:0] ef;
    drive(EXE_ADD, 32'h7FFF_FFFF, 32'h1, 1, 1, 0, 0, 0);
    ef = model_fwd();
    n_compared++;
    if (status_fwd !== ef) begin
      n_mismatched++; $display("[TB] FAIL add_fwd got %b want %b", status_fwd, ef);
    end
    tick();
    n_compared++;
    if (status_reg !== 4'b0011) begin
      n_mismatched++; $display("[TB] FAIL add_ovf got %b want %b", status_reg, 4'b0011);
    end
  endtask

  task automatic test_cmp_and();
    drive(EXE_SUB, 32'd5, 32'd5, 1, 1, 0, 0, 0);
    tick();
    n_compared++;
    if (status_reg !== 4'b1100) begin
      n_mismatched++; $display("[TB] FAIL cmp_eq got %b want %b", status_reg, 4'b1100);
    end
    drive(EXE_AND, 32'h0, 32'hFFFF_FFFF, 1, 1, 0, 0, 0);
    tick();
    n_compared++;
    if (status_reg !== 4'b1100) begin
      n_mismatched++; $display("[TB] FAIL and_keep_cv got %b want %b", status_reg, 4'b1100);
    end
  endtask

  task automatic test_no_update();
    logic [3:0] ef;
    for (int k = 0; k < 2; k++) begin
      drive(EXE_ADD, 32'h8000_0000, 32'h8000_0000, 1, (k == 0) ? 1'b0 : 1'b1, (k == 1) ? 1'b1 : 1'b0, 0, 0);
      ef = model_fwd();
      n_compared++;
      if (status_fwd !== ef) begin
        n_mismatched++; $display("[TB] FAIL noupd_fwd[%0d] got %b want %b", k, status_fwd, ef);
      end
      tick();
      n_compared++;
      if (status_reg !== 4'b1100) begin
        n_mismatched++; $display("[TB] FAIL noupd[%0d] got %b want %b", k, status_reg, 4'b1100);
      end
    end
  endtask

  task automatic test_exception();
    logic [3:0] ef;
    drive(EXE_MOV, 32'h0, 32'h0, 0, 0, 0, 1, 0);
    tick();
    n_compared++;
    if (banked !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL enter_banked got %b want 1", banked);
    end
    drive(EXE_SUB, 32'd0, 32'd1, 1, 1, 0, 0, 0);
    tick();
    n_compared++;
    if (status_reg !== 4'b0010) begin
      n_mismatched++; $display("[TB] FAIL saved_sub got %b want %b", status_reg, 4'b0010);
    end
    drive(EXE_ADD, 32'd1, 32'd1, 1, 1, 0, 0, 1);
    ef = model_fwd();
    n_compared++;
    if (status_fwd !== ef) begin
      n_mismatched++; $display("[TB] FAIL return_fwd got %b want %b", status_fwd, ef);
    end
    tick();
    n_compared++;
    if (status_reg !== 4'b1100 || banked !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL return got status=%b banked=%b want 1100 0", status_reg, banked);
    end
  endtask

  task automatic test_nested();
    drive(EXE_MOV, 32'h0, 32'h0, 0, 0, 0, 1, 0);
    tick();
    drive(EXE_ADD, 32'hFFFF_FFFF, 32'h1, 1, 1, 0, 1, 0);
    tick();
    drive(EXE_MOV, 32'h0, 32'h0, 0, 0, 0, 1, 0);
    tick();
    n_compared++;
    if (nest_err !== 1'b1 || banked !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL nest got nest=%b banked=%b want 1 1", nest_err, banked);
    end
    drive(EXE_MOV, 32'h0, 32'h0, 0, 0, 0, 0, 1);
    tick();
    n_compared++;
    if (status_reg !== 4'b1100) begin
      n_mismatched++; $display("[TB] FAIL nest_shadow got %b want %b", status_reg, 4'b1100);
    end
    drive(EXE_MOV, 32'h0, 32'h0, 0, 0, 0, 1, 0);
    tick();
    drive(EXE_MOV, 32'h0, 32'h0, 0, 0, 0, 1, 1);
    tick();
    n_compared++;
    if (banked !== m_saved || status_reg !== m_flags) begin
      n_mismatched++; $display("[TB] FAIL both_saved got banked=%b status=%b want %b %b", banked, status_reg, m_saved, m_flags);
    end
    drive(EXE_MOV, 32'h0, 32'h0, 0, 0, 0, 1, 0);
    tick();
    drive(EXE_MOV, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_compared++;
    if (status_reg !== 4'b0000 || banked !== 1'b0 || nest_err !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL async_rst got status=%b banked=%b nest=%b want 0000 0 0", status_reg, banked, nest_err);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] ef;
    logic [3:0] c;
    logic       en;
    logic       rt;
    for (int i = 0; i < 300; i++) begin
      c  = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 7) == 0);
      rt = ($urandom_range(0, 7) == 0);
      if (!m_saved && en && rt) rt = 1'b0;
      drive(c, $urandom(), ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), en, rt);
      ef = model_fwd();
      n_compared++;
      if (status_fwd !== ef) begin
        n_mismatched++; $display("[TB] FAIL rnd_fwd[%0d] got %b want %b", i, status_fwd, ef);
      end
      tick();
      n_compared++;
      if (status_reg !== m_flags || banked !== m_saved || nest_err !== m_nest) begin
        n_mismatched++;
        $display("[TB] FAIL rnd[%0d] got status=%b banked=%b nest=%b want %b %b %b",
                 i, status_reg, banked, nest_err, m_flags, m_saved, m_nest);
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_add_overflow();
    test_cmp_and();
    test_no_update();
    test_exception();
    test_nested();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
